// File: rtl/aes_pkg.sv
// Shared AES definitions for the MixColumns engines. The encryption and decryption
// datapaths both use this package: field constants, xtime and the engine FSM state type.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam int         NB       = 4;
  localparam int         COL_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Multiply by x in GF(2^8), reducing modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_columns_iter_if.sv
// Input stream (state and bypass flag) and output stream of the MixColumns engine.
// The engine connects as slave. The producer and the consumer connect as master.
interface mix_columns_iter_if;
  import aes_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [0:NB*COL_W-1]   in_data;
  logic                  in_bypass;
  logic                  out_valid;
  logic                  out_ready;
  logic [0:NB*COL_W-1]   out_data;

  modport slave (
    input  in_valid, in_data, in_bypass, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_bypass, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/mix_col_word.sv
// MixColumns transform of one 32-bit column. The column is purely combinational.
// Row 0 is the most significant byte. When bypass is set, the column passes through unchanged.
module mix_col_word
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col,
  input  logic             bypass,
  output logic [COL_W-1:0] mixed
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;

  assign {a0, a1, a2, a3} = col;

  // 3x is written as xtime(x) ^ x.
  assign b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
  assign b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
  assign b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
  assign b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);

  assign mixed = bypass ? col : {b0, b1, b2, b3};

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative forward AES MixColumns engine. The engine accepts one state and transforms
// COLS_PER_CYCLE columns per clock. It holds the result until the consumer accepts it.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  mix_columns_iter_if.slave bus
);

  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(NB - COLS_PER_CYCLE);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_t              state, state_nxt;
  logic [1:0]          cnt;
  logic                bypass_q;
  logic [0:NB*COL_W-1] work, work_nxt, out_q;
  logic                accept, last_group;

  logic [1:0]          col_idx [COLS_PER_CYCLE];
  logic [COL_W-1:0]    col_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0]    col_out [COLS_PER_CYCLE];

  // The counter is a multiple of COLS_PER_CYCLE, so cnt + g never wraps within one group.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g] = cnt + 2'(g);
    assign col_in[g]  = work[COL_W*col_idx[g] +: COL_W];

    mix_col_word u_mix (
      .col    (col_in[g]),
      .bypass (bypass_q),
      .mixed  (col_out[g])
    );
  end

  always_comb begin
    work_nxt = work;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      work_nxt[COL_W*col_idx[g] +: COL_W] = col_out[g];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal assigned here gets a default value first. Without the defaults, a path
  // that skips an assignment would infer a latch.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    last_group = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) begin
        accept    = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (cnt == LAST_CNT) begin
        last_group = 1'b1;
        state_nxt  = DONE;
      end
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers then update
  // together at the clock edge, regardless of the order of the statements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work     <= '0;
      out_q    <= '0;
      cnt      <= '0;
      bypass_q <= 1'b0;
    end else if (accept) begin
      work     <= bus.in_data;
      bypass_q <= bus.in_bypass;
      cnt      <= '0;
    end else if (state == BUSY) begin
      work <= work_nxt;
      cnt  <= cnt + STEP;
      // out_data changes only when the final group completes.
      if (last_group) out_q <= work_nxt;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = out_q;

endmodule
